// File: rtl/pc_seq_pkg.sv
// Shared encodings for the PC sequencer and the instruction decoder.
// Holds pc_mux select codes, sequencer state encodings and default vectors.
package pc_seq_pkg;

    localparam logic [1:0] PC_ADD  = 2'd0;
    localparam logic [1:0] PC_WREG = 2'd1;
    localparam logic [1:0] PC_LIT  = 2'd2;
    localparam logic [1:0] PC_SAVE = 2'd3;

    // 2'b11 is deliberately left unused and treated as an illegal state.
    typedef enum logic [1:0] {
        RUN  = 2'b00,
        WAIT = 2'b01,
        ISR  = 2'b10
    } seq_state_t;

    localparam logic [11:0] DEF_RESET_VECTOR = 12'h000;
    localparam logic [11:0] DEF_INT_VECTOR   = 12'h004;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select: ADD (+1, or +2 on skip), WREG, LIT.
// The SAVE code yields pc+1, which is the return address of a wfi.
module pc_next_mux
    import pc_seq_pkg::*;
#(
    parameter int PC_WIDTH   = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic [PC_WIDTH-1:0]   pc,
    input  logic [1:0]            pc_mux,
    input  logic                  skip,
    input  logic [DATA_WIDTH-1:0] wreg,
    input  logic [PC_WIDTH-1:0]   literal,
    output logic [PC_WIDTH-1:0]   next_pc
);

    always_comb begin
        next_pc = pc + PC_WIDTH'(1);
        case (pc_mux)
            PC_ADD:  next_pc = pc + (skip ? PC_WIDTH'(2) : PC_WIDTH'(1));
            PC_WREG: next_pc = wreg[PC_WIDTH-1:0];
            PC_LIT:  next_pc = literal;
            default: next_pc = pc + PC_WIDTH'(1);
        endcase
    end

    // Only the low PC_WIDTH bits of W can address instruction memory.
    if (DATA_WIDTH > PC_WIDTH) begin : g_wreg_hi
        logic unused_wreg_hi;
        assign unused_wreg_hi = ^wreg[DATA_WIDTH-1:PC_WIDTH];
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter plus RUN/WAIT/ISR interrupt sequencer fed by the decoder.
// Define PC_SEQ_IRQ_LATCH_EN to latch interrupt rising edges until taken.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                PC_WIDTH     = 12,
    parameter int                DATA_WIDTH   = 16,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(DEF_RESET_VECTOR),
    parameter logic [PC_WIDTH-1:0] INT_VECTOR   = PC_WIDTH'(DEF_INT_VECTOR)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic [1:0]            pc_mux,
    input  logic                  pc_save,
    input  logic                  skip,
    input  logic [DATA_WIDTH-1:0] wreg,
    input  logic [PC_WIDTH-1:0]   literal,
    input  logic                  interrupt,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  int_mux,
    output logic                  waiting,
    output logic [PC_WIDTH-1:0]   saved_pc
);

    seq_state_t          state, state_nx;
    logic [PC_WIDTH-1:0] pc_nx, saved_nx, next_pc;
    logic                irq;

    pc_next_mux #(
        .PC_WIDTH   (PC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_next_mux (
        .pc      (pc),
        .pc_mux  (pc_mux),
        .skip    (skip),
        .wreg    (wreg),
        .literal (literal),
        .next_pc (next_pc)
    );

`ifdef PC_SEQ_IRQ_LATCH_EN
    logic interrupt_q, pending;

    // Edge capture runs regardless of ce so short pulses survive stalls and ISRs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            interrupt_q <= 1'b0;
            pending     <= 1'b0;
        end else begin
            interrupt_q <= interrupt;
            if (ce && irq && (state == RUN || state == WAIT))
                pending <= 1'b0;
            else if (interrupt && !interrupt_q)
                pending <= 1'b1;
        end
    end

    assign irq = pending | interrupt;
`else
    assign irq = interrupt;
`endif

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        saved_nx = saved_pc;
        case (state)
            RUN: begin
                if (irq) begin
                    // The interrupted instruction's own PC effect becomes the return point.
                    saved_nx = next_pc;
                    pc_nx    = INT_VECTOR;
                    state_nx = ISR;
                end else if (pc_mux == PC_SAVE && pc_save) begin
                    saved_nx = next_pc;
                    state_nx = WAIT;
                end else if (pc_mux == PC_SAVE) begin
                    pc_nx = saved_pc;
                end else begin
                    pc_nx = next_pc;
                end
            end
            WAIT: begin
                if (irq) begin
                    pc_nx    = INT_VECTOR;
                    state_nx = ISR;
                end
            end
            ISR: begin
                // No nesting: only rfi leaves; a wfi here just advances like ADD.
                if (pc_mux == PC_SAVE && !pc_save) begin
                    pc_nx    = saved_pc;
                    state_nx = RUN;
                end else begin
                    pc_nx = next_pc;
                end
            end
            default: begin
                pc_nx    = RESET_VECTOR;
                state_nx = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            pc       <= RESET_VECTOR;
            saved_pc <= '0;
        end else if (ce) begin
            state    <= state_nx;
            pc       <= pc_nx;
            saved_pc <= saved_nx;
        end
    end

    assign int_mux = (state == ISR);
    assign waiting = (state == WAIT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; expected outputs are queued per step and
// checked by an independent monitor on the falling clock edge.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic [1:0]  pc_mux;
    logic        pc_save;
    logic        skip;
    logic [15:0] wreg;
    logic [11:0] literal;
    logic        interrupt;
    logic [11:0] pc;
    logic        int_mux;
    logic        waiting;
    logic [11:0] saved_pc;

    typedef struct {
        string       name;
        logic [11:0] pc;
        logic [11:0] sp;
        logic        im;
        logic        wt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    pc_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .pc_mux    (pc_mux),
        .pc_save   (pc_save),
        .skip      (skip),
        .wreg      (wreg),
        .literal   (literal),
        .interrupt (interrupt),
        .pc        (pc),
        .int_mux   (int_mux),
        .waiting   (waiting),
        .saved_pc  (saved_pc)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input string nm, input logic [11:0] epc, input logic [11:0] esp,
                            input logic eim, input logic ewt);
        exp_t e;
        e.name = nm; e.pc = epc; e.sp = esp; e.im = eim; e.wt = ewt;
        exp_q.push_back(e);
    endtask

    // Drive one decoder cycle, clock it, and queue the expected post-edge outputs.
    task automatic step(input logic [1:0] m, input logic sv, input logic sk,
                        input logic [15:0] w, input logic [11:0] l, input logic irq_in,
                        input logic c, input logic [11:0] epc, input logic [11:0] esp,
                        input logic eim, input logic ewt, input string nm);
        pc_mux = m; pc_save = sv; skip = sk; wreg = w; literal = l;
        interrupt = irq_in; ce = c;
        @(posedge clk);
        #1;
        push_exp(nm, epc, esp, eim, ewt);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (pc !== e.pc || saved_pc !== e.sp || int_mux !== e.im || waiting !== e.wt) begin
                    bad++;
                    $display("FAIL %s: got pc=%h saved_pc=%h int_mux=%b waiting=%b, want pc=%h saved_pc=%h int_mux=%b waiting=%b",
                             e.name, pc, saved_pc, int_mux, waiting, e.pc, e.sp, e.im, e.wt);
                end
            end
        end
    end

    initial begin : stimulus
        logic [11:0] sp_mid;
        reset = 1'b1; ce = 1'b1; pc_mux = PC_ADD; pc_save = 1'b0; skip = 1'b0;
        wreg = '0; literal = '0; interrupt = 1'b0;
        @(posedge clk);
        #1;
        push_exp("reset_state", 12'h000, 12'h000, 1'b0, 1'b0);
        reset = 1'b0;

        // Arithmetic: wrap on skip, literal and W register loads
        step(PC_LIT,  0, 0, 16'h0000, 12'hFFF, 0, 1, 12'hFFF, 12'h000, 0, 0, "lit_fff");
        step(PC_ADD,  0, 1, 16'h0000, 12'h000, 0, 1, 12'h001, 12'h000, 0, 0, "add_skip_wrap");
        step(PC_LIT,  0, 0, 16'h0000, 12'h123, 0, 1, 12'h123, 12'h000, 0, 0, "lit_123");
        step(PC_WREG, 0, 0, 16'hA456, 12'h000, 0, 1, 12'h456, 12'h000, 0, 0, "wreg_456");
        step(PC_ADD,  0, 0, 16'h0000, 12'h000, 0, 1, 12'h457, 12'h000, 0, 0, "add_plain");
        step(PC_LIT,  0, 0, 16'h0000, 12'h010, 0, 1, 12'h010, 12'h000, 0, 0, "lit_010");

        // wfi, idle in WAIT while decoder inputs change, wake on interrupt
        step(PC_SAVE, 1, 0, 16'h0000, 12'h000, 0, 1, 12'h010, 12'h011, 0, 1, "wfi_enter");
        for (int i = 0; i < 5; i++)
            step(2'(i), i[0], i[1], 16'h1234 + 16'(i), 12'h700 + 12'(i), 0, 1,
                 12'h010, 12'h011, 0, 1, "wait_hold");
        step(PC_ADD,  0, 0, 16'h0000, 12'h000, 1, 1, 12'h004, 12'h011, 1, 0, "wait_irq");
        step(PC_ADD,  0, 0, 16'h0000, 12'h000, 0, 1, 12'h005, 12'h011, 1, 0, "isr_add");
        step(PC_SAVE, 1, 0, 16'h0000, 12'h000, 0, 1, 12'h006, 12'h011, 1, 0, "isr_wfi_as_add");
        step(PC_SAVE, 0, 0, 16'h0000, 12'h000, 0, 1, 12'h011, 12'h011, 0, 0, "rfi_to_011");

        // Interrupt during LIT: the literal becomes the return address
        step(PC_LIT,  0, 0, 16'h0000, 12'h020, 0, 1, 12'h020, 12'h011, 0, 0, "lit_020");
        step(PC_LIT,  0, 0, 16'h0000, 12'h300, 1, 1, 12'h004, 12'h300, 1, 0, "irq_on_lit");
        step(PC_SAVE, 0, 0, 16'h0000, 12'h000, 0, 1, 12'h300, 12'h300, 0, 0, "rfi_to_300");

        // 1-cycle pulse while in ISR
        step(PC_ADD,  0, 0, 16'h0000, 12'h000, 1, 1, 12'h004, 12'h301, 1, 0, "irq_on_add");
        step(PC_ADD,  0, 0, 16'h0000, 12'h000, 0, 1, 12'h005, 12'h301, 1, 0, "isr_run1");
        step(PC_ADD,  0, 0, 16'h0000, 12'h000, 1, 1, 12'h006, 12'h301, 1, 0, "isr_pulse");
        step(PC_SAVE, 0, 0, 16'h0000, 12'h000, 0, 1, 12'h301, 12'h301, 0, 0, "rfi_to_301");
`ifdef PC_SEQ_IRQ_LATCH_EN
        step(PC_ADD,  0, 0, 16'h0000, 12'h000, 0, 1, 12'h004, 12'h302, 1, 0, "pending_reentry");
        step(PC_SAVE, 0, 0, 16'h0000, 12'h000, 0, 1, 12'h302, 12'h302, 0, 0, "rfi_to_302");
        sp_mid = 12'h302;
`else
        step(PC_ADD,  0, 0, 16'h0000, 12'h000, 0, 1, 12'h302, 12'h301, 0, 0, "pulse_dropped");
        sp_mid = 12'h301;
`endif
        step(PC_LIT,  0, 0, 16'h0000, 12'h200, 0, 1, 12'h200, sp_mid,  0, 0, "lit_200_pre");
        step(PC_LIT,  0, 0, 16'h0000, 12'h055, 1, 1, 12'h004, 12'h055, 1, 0, "irq_on_lit_055");
        step(PC_SAVE, 0, 0, 16'h0000, 12'h000, 0, 1, 12'h055, 12'h055, 0, 0, "rfi_to_055");
        step(PC_LIT,  0, 0, 16'h0000, 12'h200, 0, 1, 12'h200, 12'h055, 0, 0, "lit_200");
        step(PC_SAVE, 0, 0, 16'h0000, 12'h000, 0, 1, 12'h055, 12'h055, 0, 0, "rfi_in_run");
        step(PC_ADD,  0, 0, 16'h0000, 12'h000, 0, 1, 12'h056, 12'h055, 0, 0, "run_after_rfi");

        // ce=0 freezes everything
        step(PC_LIT,  0, 0, 16'h0000, 12'h7AB, 0, 0, 12'h056, 12'h055, 0, 0, "ce0_lit");
        step(PC_WREG, 0, 1, 16'hFFFF, 12'h000, 0, 0, 12'h056, 12'h055, 0, 0, "ce0_wreg");
        step(PC_SAVE, 1, 0, 16'h0000, 12'h000, 0, 0, 12'h056, 12'h055, 0, 0, "ce0_wfi");
        step(PC_ADD,  0, 1, 16'h0000, 12'h000, 0, 1, 12'h058, 12'h055, 0, 0, "ce1_resume");

        // Asynchronous reset in the middle of an ISR at pc=3A5
        step(PC_LIT,  0, 0, 16'h0000, 12'h3A4, 0, 1, 12'h3A4, 12'h055, 0, 0, "lit_3a4");
        step(PC_ADD,  0, 0, 16'h0000, 12'h000, 1, 1, 12'h004, 12'h3A5, 1, 0, "irq_to_isr");
        step(PC_LIT,  0, 0, 16'h0000, 12'h3A5, 0, 1, 12'h3A5, 12'h3A5, 1, 0, "isr_lit_3a5");
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (pc !== 12'h000) begin
            bad++;
            $display("FAIL async_reset_pc: got pc=%h want 000", pc);
        end
        total++;
        if (saved_pc !== 12'h000) begin
            bad++;
            $display("FAIL async_reset_saved_pc: got saved_pc=%h want 000", saved_pc);
        end
        total++;
        if (int_mux !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_int_mux: got int_mux=%b want 0", int_mux);
        end
        total++;
        if (waiting !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_waiting: got waiting=%b want 0", waiting);
        end
        push_exp("async_reset", 12'h000, 12'h000, 0, 0);
        @(posedge clk);
        #1;
        push_exp("reset_held", 12'h000, 12'h000, 0, 0);
        reset = 1'b0;
        step(PC_ADD,  0, 0, 16'h0000, 12'h000, 0, 1, 12'h001, 12'h000, 0, 0, "post_reset_add");

        repeat (2) @(negedge clk);
        #1;
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL %s: got no check, want pc=%h", e.name, e.pc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
